// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: operand forwarding, load-use stall, branch flush and MDU occupancy FSM.
// Optional performance counters (stall_cnt, flush_cnt) are built when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl #(
  parameter int MDU_LAT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rs1_d,
  input  logic [4:0]  rs2_d,
  input  logic [4:0]  rs1_e,
  input  logic [4:0]  rs2_e,
  input  logic [4:0]  rd_e,
  input  logic [4:0]  rd_m,
  input  logic [4:0]  rd_w,
  input  logic        regwritem,
  input  logic        regwritew,
  input  logic        resultsrce,
  input  logic        pcsrce,
  input  logic        mdu_start_e,
  output logic [1:0]  forwarda_e,
  output logic [1:0]  forwardb_e,
  output logic        stallf,
  output logic        stalld,
  output logic        stalle,
  output logic        flushd,
  output logic        flushe,
  output logic        bubblem,
  output logic        mdu_busy,
  output logic        mdu_done
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(MDU_LAT - 3);

  state_t     state;
  logic [3:0] cnt;
  logic       lwstall;

  // All hazard outputs are forced quiet while rst is held.
  always_comb begin
    forwarda_e = 2'b00;
    forwardb_e = 2'b00;
    if (!rst) begin
      if (regwritem && rd_m != '0 && rd_m == rs1_e)      forwarda_e = 2'b10;
      else if (regwritew && rd_w != '0 && rd_w == rs1_e) forwarda_e = 2'b01;
      if (regwritem && rd_m != '0 && rd_m == rs2_e)      forwardb_e = 2'b10;
      else if (regwritew && rd_w != '0 && rd_w == rs2_e) forwardb_e = 2'b01;
    end
  end

  always_comb begin
    lwstall  = !rst && resultsrce && rd_e != '0 && (rd_e == rs1_d || rd_e == rs2_d);
    mdu_busy = !rst && ((state == IDLE && mdu_start_e) || state == BUSY);
    mdu_done = !rst && state == DONE;
    stallf   = lwstall | mdu_busy;
    stalld   = lwstall | mdu_busy;
    stalle   = mdu_busy;
    bubblem  = mdu_busy;
    flushd   = pcsrce & ~mdu_busy & ~rst;
    flushe   = (lwstall | pcsrce) & ~mdu_busy & ~rst;
  end

  // DONE never samples mdu_start_e, so the finishing op cannot retrigger itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mdu_start_e) begin
            if (MDU_LAT == 2) begin
              state <= DONE;
            end else begin
              state <= BUSY;
              cnt   <= CNT_INIT;
            end
          end
        end
        BUSY: begin
          if (cnt == '0) state <= DONE;
          else           cnt   <= cnt - 4'd1;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stallf && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
      if (flushe && flush_cnt != '1) flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl; three instances cover MDU_LAT = 4, 2 and 8.
// Shared pipeline inputs, separate mdu_start_e per instance; index 0:LAT4, 1:LAT2, 2:LAT8.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic       regwritem, regwritew, resultsrce, pcsrce;
  logic       start [3];

  logic [1:0] fa [3];
  logic [1:0] fb [3];
  logic       sf [3], sd [3], se [3], fd [3], fe [3], bm [3], busy [3], done [3];
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] scnt [3];
  logic [31:0] fcnt [3];
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.MDU_LAT(4)) u4 (
    .clk(clk), .rst(rst), .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
    .rd_e(rd_e), .rd_m(rd_m), .rd_w(rd_w), .regwritem(regwritem), .regwritew(regwritew),
    .resultsrce(resultsrce), .pcsrce(pcsrce), .mdu_start_e(start[0]),
    .forwarda_e(fa[0]), .forwardb_e(fb[0]), .stallf(sf[0]), .stalld(sd[0]), .stalle(se[0]),
    .flushd(fd[0]), .flushe(fe[0]), .bubblem(bm[0]), .mdu_busy(busy[0]), .mdu_done(done[0])
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cnt(scnt[0]), .flush_cnt(fcnt[0])
`endif
  );

  hazard_ctrl #(.MDU_LAT(2)) u2 (
    .clk(clk), .rst(rst), .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
    .rd_e(rd_e), .rd_m(rd_m), .rd_w(rd_w), .regwritem(regwritem), .regwritew(regwritew),
    .resultsrce(resultsrce), .pcsrce(pcsrce), .mdu_start_e(start[1]),
    .forwarda_e(fa[1]), .forwardb_e(fb[1]), .stallf(sf[1]), .stalld(sd[1]), .stalle(se[1]),
    .flushd(fd[1]), .flushe(fe[1]), .bubblem(bm[1]), .mdu_busy(busy[1]), .mdu_done(done[1])
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cnt(scnt[1]), .flush_cnt(fcnt[1])
`endif
  );

  hazard_ctrl #(.MDU_LAT(8)) u8 (
    .clk(clk), .rst(rst), .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
    .rd_e(rd_e), .rd_m(rd_m), .rd_w(rd_w), .regwritem(regwritem), .regwritew(regwritew),
    .resultsrce(resultsrce), .pcsrce(pcsrce), .mdu_start_e(start[2]),
    .forwarda_e(fa[2]), .forwardb_e(fb[2]), .stallf(sf[2]), .stalld(sd[2]), .stalle(se[2]),
    .flushd(fd[2]), .flushe(fe[2]), .bubblem(bm[2]), .mdu_busy(busy[2]), .mdu_done(done[2])
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cnt(scnt[2]), .flush_cnt(fcnt[2])
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rs1_d = '0; rs2_d = '0; rs1_e = '0; rs2_e = '0; rd_e = '0; rd_m = '0; rd_w = '0;
    regwritem = 1'b0; regwritew = 1'b0; resultsrce = 1'b0; pcsrce = 1'b0;
    start[0] = 1'b0; start[1] = 1'b0; start[2] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    clear_inputs();
    rst = 1'b1;
    tick();
    // Reset held with every hazard-producing input active: all outputs must stay quiet.
    regwritem = 1'b1; rd_m = 5'd5; rs1_e = 5'd5; rs2_e = 5'd5;
    resultsrce = 1'b1; rd_e = 5'd7; rs2_d = 5'd7; pcsrce = 1'b1;
    start[0] = 1'b1; start[1] = 1'b1; start[2] = 1'b1;
    #1;
    chk("rst_fwda", fa[0], 2'b00);
    chk("rst_fwdb", fb[0], 2'b00);
    chk("rst_stallf", sf[0], 0);
    chk("rst_stalle", se[0], 0);
    chk("rst_flushd", fd[0], 0);
    chk("rst_flushe", fe[0], 0);
    chk("rst_busy", busy[0], 0);
    chk("rst_done", done[0], 0);
    tick();
    clear_inputs();
    rst = 1'b0;
    #1;
    chk("idle_busy4", busy[0], 0);
    chk("idle_done4", done[0], 0);

    // Forwarding
    regwritem = 1'b1; rd_m = 5'd5; rs1_e = 5'd5;
    regwritew = 1'b1; rd_w = 5'd6; rs2_e = 5'd6;
    #1;
    chk("fwd_a_mem", fa[0], 2'b10);
    chk("fwd_b_wb", fb[0], 2'b01);
    rd_w = 5'd5; rs2_e = 5'd5;
    #1;
    chk("fwd_b_mem_prio", fb[0], 2'b10);
    regwritem = 1'b0;
    #1;
    chk("fwd_b_wb_only", fb[0], 2'b01);
    chk("fwd_a_wb_only", fa[0], 2'b01);
    regwritem = 1'b1; rd_m = '0; rd_w = '0; rs1_e = '0; rs2_e = '0;
    #1;
    chk("fwd_a_x0", fa[0], 2'b00);
    chk("fwd_b_x0", fb[0], 2'b00);
    clear_inputs();

    // Load-use stall
    resultsrce = 1'b1; rd_e = 5'd7; rs2_d = 5'd7;
    #1;
    chk("lw_stallf", sf[0], 1);
    chk("lw_stalld", sd[0], 1);
    chk("lw_flushe", fe[0], 1);
    chk("lw_flushd", fd[0], 0);
    chk("lw_stalle", se[0], 0);
    chk("lw_bubblem", bm[0], 0);
    rd_e = '0; rs2_d = '0;
    #1;
    chk("lw_x0_stallf", sf[0], 0);
    chk("lw_x0_flushe", fe[0], 0);
    resultsrce = 1'b0;

    // Branch flush
    pcsrce = 1'b1;
    #1;
    chk("br_flushd", fd[0], 1);
    chk("br_flushe", fe[0], 1);
    chk("br_stallf", sf[0], 0);
    clear_inputs();
    tick();

    // MDU_LAT=4: three busy cycles then one done cycle
    start[0] = 1'b1;
    #1;
    chk("m4_c1_busy", busy[0], 1);
    chk("m4_c1_stalle", se[0], 1);
    chk("m4_c1_bubblem", bm[0], 1);
    chk("m4_c1_stallf", sf[0], 1);
    tick();
    chk("m4_c2_busy", busy[0], 1);
    chk("m4_c2_stalle", se[0], 1);
    tick();
    chk("m4_c3_busy", busy[0], 1);
    chk("m4_c3_stalle", se[0], 1);
    chk("m4_c3_done", done[0], 0);
    tick();
    chk("m4_c4_busy", busy[0], 0);
    chk("m4_c4_done", done[0], 1);
    chk("m4_c4_stalle", se[0], 0);
    start[0] = 1'b0;
    tick();
    chk("m4_c5_busy", busy[0], 0);
    chk("m4_c5_done", done[0], 0);

    // MDU start with concurrent load-use and branch: busy overrides flushes
    start[0] = 1'b1; resultsrce = 1'b1; rd_e = 5'd7; rs1_d = 5'd7;
    #1;
    chk("ov_flushe", fe[0], 0);
    chk("ov_stalle", se[0], 1);
    chk("ov_stallf", sf[0], 1);
    pcsrce = 1'b1;
    #1;
    chk("ov_flushd", fd[0], 0);
    pcsrce = 1'b0;
    tick();
    tick();
    tick();
    chk("ov_done", done[0], 1);
    chk("ov_done_flushe", fe[0], 1);
    chk("ov_done_stalle", se[0], 0);
    clear_inputs();
    tick();

    // MDU_LAT=2 back-to-back: busy, done, busy, done
    start[1] = 1'b1;
    #1;
    chk("m2_c1_busy", busy[1], 1);
    chk("m2_c1_done", done[1], 0);
    tick();
    chk("m2_c2_busy", busy[1], 0);
    chk("m2_c2_done", done[1], 1);
    tick();
    chk("m2_c3_busy", busy[1], 1);
    chk("m2_c3_done", done[1], 0);
    tick();
    chk("m2_c4_busy", busy[1], 0);
    chk("m2_c4_done", done[1], 1);
    start[1] = 1'b0;
    tick();
    chk("m2_c5_busy", busy[1], 0);
    chk("m2_c5_done", done[1], 0);

    // MDU_LAT=8 aborted by reset during the second BUSY cycle
    start[2] = 1'b1;
    tick();
    chk("m8_busy1", busy[2], 1);
    tick();
    chk("m8_busy2", busy[2], 1);
    rst = 1'b1; start[2] = 1'b0;
    #1;
    chk("m8_rst_busy", busy[2], 0);
    chk("m8_rst_stallf", sf[2], 0);
    tick();
    rst = 1'b0;
    #1;
    chk("m8_after_busy", busy[2], 0);
    chk("m8_after_stallf", sf[2], 0);
    chk("m8_after_done", done[2], 0);
`ifdef HAZARD_PERF_CNT_EN
    chk("m8_stall_cnt_rst", scnt[2], 0);
    chk("m8_flush_cnt_rst", fcnt[2], 0);
`endif
    tick();
    chk("m8_later_busy", busy[2], 0);
    chk("m8_later_done", done[2], 0);

`ifdef HAZARD_PERF_CNT_EN
    // Counter begins at 0 after the reset above; two load-use cycles bump both counters.
    resultsrce = 1'b1; rd_e = 5'd3; rs1_d = 5'd3;
    tick();
    tick();
    clear_inputs();
    #1;
    chk("perf_stall_cnt", scnt[2], 2);
    chk("perf_flush_cnt", fcnt[2], 2);
    start[2] = 1'b1;
    tick();
    start[2] = 1'b0;
    #1;
    chk("perf_stall_mdu", scnt[2], 3);
    chk("perf_flush_mdu", fcnt[2], 2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
